// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on MemReady,
// traps illegal opcodes, halts on bus timeout and counts retired instructions.
module mips_mc_ctrl #(
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               MemReq,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCEn,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ExtOp,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic [3:0]         State,
  output logic               IllegalOp,
  output logic               BusErr,
  output logic               InsRetired,
  output logic [CNT_W-1:0]   InsCount
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);

  localparam int WCNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               is_ori;
  logic [WCNT_W-1:0]  wait_cnt;
  logic               mem_wait;
  logic               timeout;
  logic               ill_q;
  logic               berr_q;
  logic [CNT_W-1:0]   count_q;

  assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !MemReady;
  // A ready on the cycle the counter hits the limit still completes the access.
  assign timeout  = (TIMEOUT_CYC != 0) && mem_wait && (wait_cnt == WCNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH: begin
        if (MemReady)     next_state = S_DECODE;
        else if (timeout) next_state = S_HALT;
      end
      S_DECODE: begin
        unique case (Opcode)
          OP_R:            next_state = S_EXEC_R;
          OP_LW, OP_SW:    next_state = S_MEMADR;
          OP_BEQ:          next_state = S_BRANCH;
          OP_J:            next_state = S_JUMP;
          OP_ADDI, OP_ORI: next_state = S_EXEC_I;
          default:         next_state = S_TRAP;
        endcase
      end
      S_EXEC_R: next_state = S_WB_R;
      S_EXEC_I: next_state = S_WB_I;
      S_MEMADR: next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (MemReady)     next_state = S_MEMWB;
        else if (timeout) next_state = S_HALT;
      end
      S_MEMWR: begin
        if (MemReady)     next_state = S_FETCH;
        else if (timeout) next_state = S_HALT;
      end
      S_WB_R, S_WB_I, S_MEMWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    MemReq     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCEn       = 1'b0;
    PCSource   = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    ExtOp      = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    InsRetired = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCEn    = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = is_ori ? ALU_OR : ALU_ADD;
        ExtOp   = !is_ori;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEMRD: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemReq     = 1'b1;
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        InsRetired = MemReady;
      end
      S_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        InsRetired = 1'b1;
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        InsRetired = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        InsRetired = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        PCSource   = 2'b01;
        PCEn       = Zero;
        InsRetired = 1'b1;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCEn       = 1'b1;
        InsRetired = 1'b1;
      end
      default: ;
    endcase
    // Reset forces every control quiet at once, abandoning any access in flight.
    if (rst) begin
      MemReq     = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCEn       = 1'b0;
      PCSource   = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = ALU_ADD;
      ExtOp      = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      InsRetired = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ill_q    <= 1'b0;
      berr_q   <= 1'b0;
      count_q  <= '0;
      wait_cnt <= '0;
      is_ori   <= 1'b0;
    end else begin
      if (next_state == S_TRAP) ill_q  <= 1'b1;
      if (next_state == S_HALT) berr_q <= 1'b1;
      if (InsRetired)           count_q <= count_q + CNT_W'(1);
      if (mem_wait)             wait_cnt <= wait_cnt + WCNT_W'(1);
      else                      wait_cnt <= '0;
      if (state == S_DECODE)    is_ori <= (Opcode == OP_ORI);
    end
  end

  assign State     = state;
  assign IllegalOp = ill_q  && !rst;
  assign BusErr    = berr_q && !rst;
  assign InsCount  = rst ? '0 : count_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: table of per-cycle vectors plus directed multi-cycle sequences
// for wait states, trap, bus timeout, counter wrap and reset mid-access.
module tb_mips_mc_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Packed expected outputs: State, {MemReq,IorD,MemRead,MemWrite,IRWrite,PCEn}, PCSource,
  // {ALUSrcA,ALUSrcB}, ALUOp, {ExtOp,RegDst,MemtoReg,RegWrite,InsRetired}
  localparam logic [22:0] O_RST     = {4'd0,  6'b000000, 2'b00, 3'b000, 3'b000, 5'b00000};
  localparam logic [22:0] O_FETCH_W = {4'd0,  6'b101000, 2'b00, 3'b001, 3'b000, 5'b00000};
  localparam logic [22:0] O_FETCH   = {4'd0,  6'b101011, 2'b00, 3'b001, 3'b000, 5'b00000};
  localparam logic [22:0] O_DECODE  = {4'd1,  6'b000000, 2'b00, 3'b011, 3'b000, 5'b10000};
  localparam logic [22:0] O_EXEC_R  = {4'd2,  6'b000000, 2'b00, 3'b100, 3'b010, 5'b00000};
  localparam logic [22:0] O_WB_R    = {4'd3,  6'b000000, 2'b00, 3'b000, 3'b000, 5'b01011};
  localparam logic [22:0] O_EX_ADDI = {4'd4,  6'b000000, 2'b00, 3'b110, 3'b000, 5'b10000};
  localparam logic [22:0] O_EX_ORI  = {4'd4,  6'b000000, 2'b00, 3'b110, 3'b011, 5'b00000};
  localparam logic [22:0] O_WB_I    = {4'd5,  6'b000000, 2'b00, 3'b000, 3'b000, 5'b00011};
  localparam logic [22:0] O_MEMADR  = {4'd6,  6'b000000, 2'b00, 3'b110, 3'b000, 5'b10000};
  localparam logic [22:0] O_MEMRD   = {4'd7,  6'b111000, 2'b00, 3'b000, 3'b000, 5'b00000};
  localparam logic [22:0] O_MEMWB   = {4'd8,  6'b000000, 2'b00, 3'b000, 3'b000, 5'b00111};
  localparam logic [22:0] O_MEMWR_W = {4'd9,  6'b110100, 2'b00, 3'b000, 3'b000, 5'b00000};
  localparam logic [22:0] O_MEMWR   = {4'd9,  6'b110100, 2'b00, 3'b000, 3'b000, 5'b00001};
  localparam logic [22:0] O_BR_T    = {4'd10, 6'b000001, 2'b01, 3'b100, 3'b001, 5'b00001};
  localparam logic [22:0] O_BR_N    = {4'd10, 6'b000000, 2'b01, 3'b100, 3'b001, 5'b00001};
  localparam logic [22:0] O_JUMP    = {4'd11, 6'b000001, 2'b10, 3'b000, 3'b000, 5'b00001};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [22:0] outs;
    logic [3:0]  cnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, IorD, MemRead, MemWrite, IRWrite, PCEn;
  logic [1:0] PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       ExtOp, RegDst, MemtoReg, RegWrite;
  logic [3:0] State;
  logic       IllegalOp, BusErr, InsRetired;
  logic [3:0] InsCount;

  int tests = 0;
  int fails = 0;

  mips_mc_ctrl #(.ALUOP_W(3), .TIMEOUT_CYC(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .State(State), .IllegalOp(IllegalOp),
    .BusErr(BusErr), .InsRetired(InsRetired), .InsCount(InsCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    Opcode   = v.op;
    Zero     = v.zero;
    MemReady = v.rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction from FETCH, stretching each memory access by the given wait counts.
  task automatic runInstr(input logic [5:0] op, input logic z, input int fwaits, input int mwaits,
                          output int cycles, output int dreq);
    int  fseen;
    int  mseen;
    bit  done;
    cycles = 0;
    dreq   = 0;
    fseen  = 0;
    mseen  = 0;
    done   = 1'b0;
    Opcode = op;
    Zero   = z;
    for (int k = 0; k < 40 && !done; k++) begin
      MemReady = 1'b1;
      if (State == 4'd0 && fseen < fwaits) begin
        MemReady = 1'b0;
        fseen++;
      end
      if ((State == 4'd7 || State == 4'd9) && mseen < mwaits) begin
        MemReady = 1'b0;
        mseen++;
      end
      #1;
      cycles++;
      if (MemReq && IorD) dreq++;
      if (InsRetired) done = 1'b1;
      step();
    end
    if (!done) checkOutput("runInstr retire within budget", 32'd0, 32'd1);
  endtask

  vec_t vq[$];
  logic [22:0] act_outs;
  int cyc, dreq, halt_at, bad;

  initial begin
    vq.push_back('{1'b1, OP_R,    1'b0, 1'b1, O_RST,     4'd0});
    vq.push_back('{1'b0, OP_R,    1'b0, 1'b0, O_FETCH_W, 4'd0});
    vq.push_back('{1'b0, OP_R,    1'b0, 1'b1, O_FETCH,   4'd0});
    vq.push_back('{1'b0, OP_R,    1'b0, 1'b1, O_DECODE,  4'd0});
    vq.push_back('{1'b0, OP_R,    1'b0, 1'b1, O_EXEC_R,  4'd0});
    vq.push_back('{1'b0, OP_R,    1'b0, 1'b1, O_WB_R,    4'd0});
    vq.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, O_FETCH,   4'd1});
    vq.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, O_DECODE,  4'd1});
    vq.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, O_EX_ADDI, 4'd1});
    vq.push_back('{1'b0, OP_ADDI, 1'b0, 1'b1, O_WB_I,    4'd1});
    vq.push_back('{1'b0, OP_ORI,  1'b0, 1'b1, O_FETCH,   4'd2});
    vq.push_back('{1'b0, OP_ORI,  1'b0, 1'b1, O_DECODE,  4'd2});
    vq.push_back('{1'b0, OP_ORI,  1'b0, 1'b1, O_EX_ORI,  4'd2});
    vq.push_back('{1'b0, OP_ORI,  1'b0, 1'b1, O_WB_I,    4'd2});
    vq.push_back('{1'b0, OP_LW,   1'b0, 1'b1, O_FETCH,   4'd3});
    vq.push_back('{1'b0, OP_LW,   1'b0, 1'b1, O_DECODE,  4'd3});
    vq.push_back('{1'b0, OP_LW,   1'b0, 1'b1, O_MEMADR,  4'd3});
    vq.push_back('{1'b0, OP_LW,   1'b0, 1'b1, O_MEMRD,   4'd3});
    vq.push_back('{1'b0, OP_LW,   1'b0, 1'b1, O_MEMWB,   4'd3});
    vq.push_back('{1'b0, OP_SW,   1'b0, 1'b1, O_FETCH,   4'd4});
    vq.push_back('{1'b0, OP_SW,   1'b0, 1'b1, O_DECODE,  4'd4});
    vq.push_back('{1'b0, OP_SW,   1'b0, 1'b1, O_MEMADR,  4'd4});
    vq.push_back('{1'b0, OP_SW,   1'b0, 1'b0, O_MEMWR_W, 4'd4});
    vq.push_back('{1'b0, OP_SW,   1'b0, 1'b1, O_MEMWR,   4'd4});
    vq.push_back('{1'b0, OP_BEQ,  1'b1, 1'b1, O_FETCH,   4'd5});
    vq.push_back('{1'b0, OP_BEQ,  1'b1, 1'b1, O_DECODE,  4'd5});
    vq.push_back('{1'b0, OP_BEQ,  1'b1, 1'b1, O_BR_T,    4'd5});
    vq.push_back('{1'b0, OP_BEQ,  1'b0, 1'b1, O_FETCH,   4'd6});
    vq.push_back('{1'b0, OP_BEQ,  1'b0, 1'b1, O_DECODE,  4'd6});
    vq.push_back('{1'b0, OP_BEQ,  1'b0, 1'b1, O_BR_N,    4'd6});
    vq.push_back('{1'b0, OP_J,    1'b0, 1'b1, O_FETCH,   4'd7});
    vq.push_back('{1'b0, OP_J,    1'b0, 1'b1, O_DECODE,  4'd7});
    vq.push_back('{1'b0, OP_J,    1'b0, 1'b1, O_JUMP,    4'd7});

    rst = 1'b1; Opcode = '0; Zero = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vq[i]) begin
      applyStimulus(vq[i]);
      act_outs = {State, MemReq, IorD, MemRead, MemWrite, IRWrite, PCEn, PCSource,
                  ALUSrcA, ALUSrcB, ALUOp, ExtOp, RegDst, MemtoReg, RegWrite, InsRetired};
      checkOutput($sformatf("row%0d outputs", i), 32'(act_outs), 32'(vq[i].outs));
      checkOutput($sformatf("row%0d InsCount", i), 32'(InsCount), 32'(vq[i].cnt));
      step();
    end
    checkOutput("InsCount after table", 32'(InsCount), 32'd8);
    checkOutput("flags after table", {30'd0, IllegalOp, BusErr}, 32'd0);

    // lw with three wait states in MEMRD
    doReset();
    runInstr(OP_LW, 1'b0, 0, 3, cyc, dreq);
    checkOutput("lw wait total cycles", 32'(cyc), 32'd8);
    checkOutput("lw wait data MemReq cycles", 32'(dreq), 32'd4);
    checkOutput("lw wait InsCount", 32'(InsCount), 32'd1);

    runInstr(OP_BEQ, 1'b1, 0, 0, cyc, dreq);
    checkOutput("beq taken cycles", 32'(cyc), 32'd3);
    runInstr(OP_BEQ, 1'b0, 0, 0, cyc, dreq);
    checkOutput("beq not-taken cycles", 32'(cyc), 32'd3);
    runInstr(OP_R, 1'b0, 0, 0, cyc, dreq);
    checkOutput("R-type cycles", 32'(cyc), 32'd4);
    runInstr(OP_SW, 1'b0, 0, 0, cyc, dreq);
    checkOutput("sw cycles", 32'(cyc), 32'd4);
    checkOutput("InsCount after mix", 32'(InsCount), 32'd5);

    // Illegal opcode: trap holds all enables off until reset
    doReset();
    Opcode = OP_BAD; MemReady = 1'b1;
    step();
    step();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (PCEn || RegWrite || MemWrite || MemReq || InsRetired || !IllegalOp || State != 4'd12) bad++;
      step();
    end
    checkOutput("trap hold violations", 32'(bad), 32'd0);
    checkOutput("trap InsCount", 32'(InsCount), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("IllegalOp masked during rst", 32'(IllegalOp), 32'd0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("IllegalOp cleared by rst", 32'(IllegalOp), 32'd0);
    checkOutput("State FETCH after trap rst", 32'(State), 32'd0);
    step();

    // Bus timeout: MemReady never arrives in FETCH
    doReset();
    MemReady = 1'b0;
    halt_at = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (State == 4'd13 && halt_at == 0) halt_at = c;
      step();
    end
    #1;
    checkOutput("timeout HALT entry cycle", 32'(halt_at), 32'd6);
    checkOutput("timeout BusErr", 32'(BusErr), 32'd1);
    checkOutput("timeout State", 32'(State), 32'd13);
    checkOutput("timeout MemReq", 32'(MemReq), 32'd0);

    // MemReady on the fifth FETCH cycle beats the timeout
    doReset();
    Opcode = OP_J; MemReady = 1'b0;
    repeat (4) step();
    MemReady = 1'b1;
    #1;
    checkOutput("late ready IRWrite", 32'(IRWrite), 32'd1);
    step();
    #1;
    checkOutput("late ready State DECODE", 32'(State), 32'd1);
    checkOutput("late ready BusErr", 32'(BusErr), 32'd0);
    step();

    // 4-bit retire counter wraps after 16 instructions
    doReset();
    for (int n = 1; n <= 17; n++) begin
      runInstr(OP_J, 1'b0, 0, 0, cyc, dreq);
      if (n == 15) checkOutput("InsCount after 15", 32'(InsCount), 32'd15);
      if (n == 16) checkOutput("InsCount wrap after 16", 32'(InsCount), 32'd0);
    end
    checkOutput("InsCount after 17", 32'(InsCount), 32'd1);

    // Reset while a store is waiting in MEMWR
    Opcode = OP_SW; MemReady = 1'b1;
    repeat (3) step();
    MemReady = 1'b0;
    #1;
    checkOutput("sw in MEMWR", 32'(State), 32'd9);
    checkOutput("sw MemReq before rst", 32'(MemReq), 32'd1);
    step();
    rst = 1'b1;
    #1;
    checkOutput("MemReq dropped by rst", 32'(MemReq), 32'd0);
    checkOutput("no retire under rst", 32'(InsRetired), 32'd0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("InsCount cleared by rst", 32'(InsCount), 32'd0);
    checkOutput("State FETCH after rst", 32'(State), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
